// File: rtl/spi_deserializer.sv
// SPI receive deserializer: oversamples sclk/mosi, assembles MSB-first words and pushes them
// into an RX FIFO through a one-word hold buffer, flagging dropped words and aborted frames.
module spi_deserializer #(
    parameter int unsigned DATAWIDTH       = 32,
    parameter int unsigned BITCOUNTERWIDTH = $clog2(DATAWIDTH),
    parameter int unsigned SYNC_STAGES     = 2,
    parameter bit          SAMPLE_EDGE     = 1'b0,
    parameter int unsigned TIMEOUT         = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sclk_i,
    input  logic                 mosi_i,
    input  logic                 frame_end_i,
    input  logic                 full_i,
    input  logic                 clr_err_i,
    output logic                 write_en_o,
    output logic [DATAWIDTH-1:0] write_data_o,
    output logic                 busy_o,
    output logic                 overflow_o,
    output logic                 frame_err_o
);

    localparam int unsigned CntW = BITCOUNTERWIDTH + 1;
    localparam int unsigned ToW  = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] LastBit = CntW'(DATAWIDTH - 1);
    localparam logic [ToW-1:0]  ToMax   = ToW'(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StRx, StPush, StAbort} state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q;
    logic                   sclk_q;
    logic [DATAWIDTH-1:0]   shift_q, shift_d;
    logic [DATAWIDTH-1:0]   hold_q, hold_d;
    logic                   hold_vld_q, hold_vld_d;
    logic [CntW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [ToW-1:0]         to_cnt_q, to_cnt_d;
    logic                   write_en_q;
    logic [DATAWIDTH-1:0]   write_data_q;
    logic                   overflow_q, overflow_d;
    logic                   frame_err_q, frame_err_d;

    logic sclk_s, mosi_s, sample, complete, partial, timeout_hit, abort_evt;
    logic push, accept, drop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            sclk_q      <= 1'b0;
        end else begin
            sclk_sync_q[0] <= sclk_i;
            mosi_sync_q[0] <= mosi_i;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sclk_sync_q[i] <= sclk_sync_q[i-1];
                mosi_sync_q[i] <= mosi_sync_q[i-1];
            end
            sclk_q <= sclk_s;
        end
    end

    assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    assign sample      = SAMPLE_EDGE ? (sclk_q & ~sclk_s) : (~sclk_q & sclk_s);
    assign complete    = sample & (bit_cnt_q == LastBit);
    assign partial     = (bit_cnt_q != '0);
    assign timeout_hit = (to_cnt_q == ToMax);
    // A frame_end coinciding with the completing sample is a clean word boundary.
    assign abort_evt   = partial & ~complete & (frame_end_i | timeout_hit);
    assign accept      = complete & (state_q != StAbort) & ~((state_q == StPush) & full_i);
    assign drop        = complete & (state_q == StPush) & full_i;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (sample) state_d = StRx;
            end
            StRx: begin
                if (complete) begin
                    state_d = StPush;
                end else if (abort_evt) begin
                    state_d = StAbort;
                end
            end
            StPush: begin
                if (complete) begin
                    state_d = StPush;
                end else if (abort_evt) begin
                    state_d = StAbort;
                end else if (!full_i) begin
                    state_d = (bit_cnt_d != '0) ? StRx : StIdle;
                end
            end
            StAbort: begin
                state_d = hold_vld_q ? StPush : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        push   = (state_q == StPush) & ~full_i;
        busy_o = (state_q != StIdle);
    end

    always_comb begin
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        to_cnt_d    = to_cnt_q;
        hold_d      = hold_q;
        hold_vld_d  = hold_vld_q;
        overflow_d  = overflow_q;
        frame_err_d = frame_err_q;

        if (state_q == StAbort) begin
            shift_d   = '0;
            bit_cnt_d = '0;
        end else if (sample) begin
            shift_d   = {shift_q[DATAWIDTH-2:0], mosi_s};
            bit_cnt_d = complete ? '0 : bit_cnt_q + 1'b1;
        end

        if (state_q == StAbort || sample || !partial) begin
            to_cnt_d = '0;
        end else if (!timeout_hit) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end

        if (push) hold_vld_d = 1'b0;
        if (accept) begin
            hold_d     = {shift_q[DATAWIDTH-2:0], mosi_s};
            hold_vld_d = 1'b1;
        end

        // Error events take priority over a simultaneous clear.
        if (clr_err_i) begin
            overflow_d  = 1'b0;
            frame_err_d = 1'b0;
        end
        if (drop) overflow_d = 1'b1;
        if (state_q == StAbort) frame_err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            to_cnt_q     <= '0;
            hold_q       <= '0;
            hold_vld_q   <= 1'b0;
            write_en_q   <= 1'b0;
            write_data_q <= '0;
            overflow_q   <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            to_cnt_q    <= to_cnt_d;
            hold_q      <= hold_d;
            hold_vld_q  <= hold_vld_d;
            write_en_q  <= push;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
            if (push) write_data_q <= hold_q;
        end
    end

    assign write_en_o   = write_en_q;
    assign write_data_o = write_data_q;
    assign overflow_o   = overflow_q;
    assign frame_err_o  = frame_err_q;

endmodule
